// File: rtl/aes_pkg.sv
// Shared AES SubBytes definitions: FIPS-197 S-box tables, state type, byte indexing and ShiftRows.
package aes_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

  // Byte k of the 128-bit state sits at bits [127-8k -: 8], so index 15-k of a packed byte array.
  typedef logic [15:0][7:0] state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [3:0] byte_of(input int k);
    return 4'(15 - k);
  endfunction

  // Byte k is row k%4, column k/4; forward takes out[r,c] = s[r,(c+r)%4], inverse s[r,(c-r)%4].
  function automatic state_t shift_rows(input state_t s, input logic inv);
    state_t o;
    int sc;
    o = s;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sc = inv ? (c + 4 - r) % 4 : (c + r) % 4;
        o[byte_of(r + 4 * c)] = s[byte_of(r + 4 * sc)];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_sbox_lane.sv
// One combinational S-box lane: forward or inverse substitution of a single byte, no latency.
module aes_sbox_lane
  import aes_pkg::*;
(
  input  logic       inv,
  input  logic [7:0] din,
  output logic [7:0] dout
);

  assign dout = inv ? INV_SBOX[din] : SBOX[din];

endmodule

// File: rtl/aes_sub_bytes_engine.sv
// 128-bit SubBytes/InvSubBytes over LANES S-box lanes; out_valid NBEATS+1 cycles after accept, result held until out_ready.
// AES_SUBBYTES_SHIFTROWS_EN folds (Inv)ShiftRows into the output wiring.
module aes_sub_bytes_engine
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_inv,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int NBEATS = 16 / LANES;
  localparam int CW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("aes_sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
  end

  fsm_e          fsm;
  logic [CW-1:0] cnt;
  state_t        st;
  state_t        st_next;
  logic          inv_q;
  logic          rdy_q;
  logic          vld_q;
  logic          busy_q;
  logic          accept;
  logic [7:0]    lane_in  [LANES];
  logic [7:0]    lane_out [LANES];

  // In DONE the next block may enter on the same edge the result leaves.
  assign in_ready  = rdy_q | (vld_q & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = vld_q;
  assign busy      = busy_q;

`ifdef AES_SUBBYTES_SHIFTROWS_EN
  assign out_data = shift_rows(st, inv_q);
`else
  assign out_data = st;
`endif

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_in[l] = st[byte_of(int'(cnt) * LANES + l)];
    aes_sbox_lane u_lane (
      .inv  (inv_q),
      .din  (lane_in[l]),
      .dout (lane_out[l])
    );
  end

  always_comb begin
    st_next = st;
    for (int l = 0; l < LANES; l++) begin
      st_next[byte_of(int'(cnt) * LANES + l)] = lane_out[l];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm    <= IDLE;
      cnt    <= '0;
      st     <= '0;
      inv_q  <= 1'b0;
      rdy_q  <= 1'b0;
      vld_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          rdy_q <= 1'b1;
          if (accept) begin
            st     <= in_data;
            inv_q  <= in_inv;
            cnt    <= '0;
            rdy_q  <= 1'b0;
            busy_q <= 1'b1;
            fsm    <= RUN;
          end
        end
        RUN: begin
          st <= st_next;
          if (cnt == CW'(NBEATS - 1)) begin
            vld_q <= 1'b1;
            fsm   <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            vld_q <= 1'b0;
            if (in_valid) begin
              st    <= in_data;
              inv_q <= in_inv;
              cnt   <= '0;
              fsm   <= RUN;
            end else begin
              busy_q <= 1'b0;
              rdy_q  <= 1'b1;
              fsm    <= IDLE;
            end
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule
